// File: rtl/lsu_byte_master.sv
// Byte-serial load/store initiator: one op becomes 1/2/4 req/ack byte transactions, then a done pulse.
// Optional MISALIGN_TRAP_EN: misaligned H/W ops finish with no memory traffic and pulse misalign_o.
module lsu_byte_master #(
   parameter int          ADDR_W    = 16,
   parameter logic [31:0] BASE_ADDR = 32'h0010_0000
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic              is_load_i,
   input  logic              is_store_i,
   input  logic [5:0]        alucode_i,
   input  logic [31:0]       rs1_data_i,
   input  logic [31:0]       imm_i,
   input  logic [31:0]       rs2_data_i,
   output logic              busy_o,
   output logic              done_o,
   output logic [31:0]       rd_data_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [7:0]        mem_wdata_o,
   input  logic              mem_ack_i,
   input  logic [7:0]        mem_rdata_i
`ifdef MISALIGN_TRAP_EN
   ,
   output logic              misalign_o
`endif
);

   // alucode encoding shared with the execute stage
   localparam logic [5:0] ALU_LB  = 6'd24;
   localparam logic [5:0] ALU_LH  = 6'd25;
   localparam logic [5:0] ALU_LW  = 6'd26;
   localparam logic [5:0] ALU_LBU = 6'd27;
   localparam logic [5:0] ALU_LHU = 6'd28;
   localparam logic [5:0] ALU_SB  = 6'd29;
   localparam logic [5:0] ALU_SH  = 6'd30;
   localparam logic [5:0] ALU_SW  = 6'd31;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_XFER = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [1:0]        idx_q, idx_d;
   logic [1:0]        last_q, last_d;
   logic              store_q, store_d;
   logic              sext_q, sext_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       bytes_q, bytes_d;
   logic [31:0]       rd_q, rd_d;

   logic [ADDR_W-1:0] base_calc;
   logic              op_ok, op_sext, op_go;
   logic [1:0]        op_last;

   function automatic logic [31:0] extend(input logic [31:0] b, input logic [1:0] last,
                                          input logic sx);
      logic [31:0] r;
      case (last)
         2'd0:    r = sx ? {{24{b[7]}}, b[7:0]}   : {24'd0, b[7:0]};
         2'd1:    r = sx ? {{16{b[15]}}, b[15:0]} : {16'd0, b[15:0]};
         default: r = b;
      endcase
      return r;
   endfunction

   assign base_calc = ADDR_W'(rs1_data_i + imm_i - BASE_ADDR);

   // op_last is the index of the final byte (nbytes-1); store wins when both flags are set
   always_comb begin
      op_ok   = 1'b0;
      op_last = 2'd0;
      op_sext = 1'b0;
      if (is_store_i) begin
         case (alucode_i)
            ALU_SB:  op_ok = 1'b1;
            ALU_SH:  begin op_ok = 1'b1; op_last = 2'd1; end
            ALU_SW:  begin op_ok = 1'b1; op_last = 2'd3; end
            default: op_ok = 1'b0;
         endcase
      end else begin
         case (alucode_i)
            ALU_LB:  begin op_ok = 1'b1; op_sext = 1'b1; end
            ALU_LBU: op_ok = 1'b1;
            ALU_LH:  begin op_ok = 1'b1; op_last = 2'd1; op_sext = 1'b1; end
            ALU_LHU: begin op_ok = 1'b1; op_last = 2'd1; end
            ALU_LW:  begin op_ok = 1'b1; op_last = 2'd3; end
            default: op_ok = 1'b0;
         endcase
      end
   end

`ifdef MISALIGN_TRAP_EN
   logic mis_q, mis_d, op_mis;
   assign op_mis = op_ok && ((op_last == 2'd1 && base_calc[0]) ||
                             (op_last == 2'd3 && base_calc[1:0] != 2'b00));
   assign op_go  = op_ok && !op_mis;
   assign misalign_o = done_o && mis_q;
`else
   assign op_go = op_ok;
`endif

   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      idx_d   = idx_q;
      last_d  = last_q;
      store_d = store_q;
      sext_d  = sext_q;
      wdata_d = wdata_q;
      bytes_d = bytes_q;
      rd_d    = rd_q;
`ifdef MISALIGN_TRAP_EN
      mis_d   = mis_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start_i && (is_load_i || is_store_i)) begin
               base_d  = base_calc;
               idx_d   = 2'd0;
               last_d  = op_last;
               store_d = is_store_i;
               sext_d  = op_sext;
               wdata_d = rs2_data_i;
               bytes_d = 32'd0;
`ifdef MISALIGN_TRAP_EN
               mis_d   = op_mis;
`endif
               if (op_go) begin
                  state_d = S_XFER;
               end else begin
                  state_d = S_DONE;
                  rd_d    = 32'd0;
               end
            end
         end
         S_XFER: begin
            if (mem_ack_i) begin
               bytes_d[{idx_q, 3'b000} +: 8] = mem_rdata_i;
               idx_d = idx_q + 2'd1;
               if (idx_q == last_q) begin
                  state_d = S_DONE;
                  rd_d    = store_q ? 32'd0 : extend(bytes_d, last_q, sext_q);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         base_q  <= '0;
         idx_q   <= 2'd0;
         last_q  <= 2'd0;
         store_q <= 1'b0;
         sext_q  <= 1'b0;
         wdata_q <= 32'd0;
         bytes_q <= 32'd0;
         rd_q    <= 32'd0;
`ifdef MISALIGN_TRAP_EN
         mis_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         idx_q   <= idx_d;
         last_q  <= last_d;
         store_q <= store_d;
         sext_q  <= sext_d;
         wdata_q <= wdata_d;
         bytes_q <= bytes_d;
         rd_q    <= rd_d;
`ifdef MISALIGN_TRAP_EN
         mis_q   <= mis_d;
`endif
      end
   end

   // address/data are pure functions of held registers, so they stay stable through wait states
   assign busy_o      = (state_q != S_IDLE);
   assign done_o      = (state_q == S_DONE);
   assign rd_data_o   = rd_q;
   assign mem_req_o   = (state_q == S_XFER);
   assign mem_we_o    = (state_q == S_XFER) && store_q;
   assign mem_addr_o  = base_q + ADDR_W'(idx_q);
   assign mem_wdata_o = wdata_q[{idx_q, 3'b000} +: 8];

endmodule
